mc_controller: RTL
==================

# mc_controller

Parameterised multicycle controller for the 16-bit SIMPLE machine. It sequences fetch, decode, execute and write-back against the existing datapath, and owns the PC and data-address registers. It adds three things to the fixed-width controller: a memory ready handshake with wait states, LDR/STR, and conditional branches. It sits between instruction RAM/IR and the datapath inside `cpu`.

## Interface
- `ADDR_W`, 9, width of PC, data address and `mem_addr`
- `RESET_PC`, 0, PC value loaded on reset
- `BRANCH_EN`, 1, 1 = B-class instructions decoded; 0 = treated as undefined
- `clk` in 1 — sole clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `ir` in 16 — instruction register contents
- `N`, `V`, `Z` in 1 each — status flags from datapath
- `datapath_out` in ADDR_W — low bits of datapath C output
- `mem_ready` in 1 — memory accepted/completed current `mem_cmd`
- `mem_cmd` out 2 — 00 NONE, 01 READ, 10 WRITE
- `mem_addr` out ADDR_W — PC in fetch states, data address in memory states
- `pc` out ADDR_W — current PC
- `load_ir` out 1 — load instruction register
- `nsel` out 3 — one-hot: [0] Rn, [1] Rd, [2] Rm
- `vsel` out 4 — one-hot: [3] mdata, [2] sximm8, [1] PC, [0] C
- `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`, `write` out 1 each — datapath controls
- `halted` out 1 — high in HALT state

## Operation
- Reset (async) sets state RST, `pc`=RESET_PC, daddr=0. All outputs 0 and `mem_cmd`=NONE while in RST.
- RST→IF1 on first edge after reset deasserts.
- Fetch sequence:
  - IF1: `mem_cmd`=READ, `mem_addr`=pc. Holds while `mem_ready`=0; →IF2 when 1.
  - IF2: READ held, `load_ir`=1, →UPC.
  - UPC: pc←pc+1 mod 2^ADDR_W; dispatch on {ir[15:13], ir[12:11]}.
- Dispatch (each path returns to IF1):
  - 11010 MOV imm: WRI (nsel=Rn, vsel=sximm8, write).
  - 11000 MOV shift: GETB (nsel=Rm, loadb) → ALU (asel=1, loadc) → WB (nsel=Rd, vsel=C, write).
  - 10111 MVN: same path as MOV shift.
  - 10100 ADD, 10110 AND: GETA (nsel=Rn, loada) → GETB → ALU (asel=0, bsel=0, loadc) → WB.
  - 10101 CMP: GETA → GETB → CMPS (loads=1, loadc=0).
  - 01100 LDR: GETA → ADDR (bsel=1, loadc) → LDA (daddr←datapath_out) → MRD (READ at daddr, hold until `mem_ready`) → LWB (READ held, nsel=Rd, vsel=mdata, write).
  - 10000 STR: GETA → ADDR → LDA → GETD (nsel=Rd, loadb) → PASS (asel=1, loadc) → MWR (WRITE at daddr, hold until `mem_ready`).
  - 00100 B, when BRANCH_EN: BR state. Condition ir[10:8]: 000 always, 001 Z, 010 !Z, 011 N≠V, 100 (N≠V)|Z. Taken: pc←pc+sximm8(ir[7:0]), truncated to ADDR_W. Not taken: pc unchanged.
  - 111xx: HALT.
  - Any other encoding: HALT.
- HALT: `halted`=1, all other outputs 0. Left only by reset.
- Outputs are Moore-decoded from state. Controls not listed for a state are 0.

## Timing
- Zero-wait latency in cycles, UPC inclusive:
  - MOV imm 4, B 4
  - MOV shift / MVN / CMP 6
  - ADD / AND 7
  - LDR 8, STR 9
- Each cycle with `mem_ready`=0 in IF1/MRD/MWR adds one cycle. There is no timeout.
- `mem_ready` is sampled only in IF1/MRD/MWR; it is ignored elsewhere.
- `mem_cmd` and `mem_addr` stay stable for every wait cycle.
- Reset mid-instruction aborts it immediately: `mem_cmd`→NONE combinationally and no `write` is issued.
- PC wraps 2^ADDR_W−1→0. Backward branch below 0 wraps modulo 2^ADDR_W.

## Structure
- Package `mc_pkg` holds:
  - the state enum
  - MEM_NONE/READ/WRITE
  - opcode/op constants
  - NSEL_* and VSEL_* one-hot constants
  - condition codes
- Sub-module `mc_branch_cond`: combinational (cond[2:0], N, V, Z) → taken.
- PC and daddr registers live in `mc_controller`.

## Test plan
- Reset with RESET_PC=5 → pc=5, `mem_cmd`=00. After release: IF1 at `mem_addr`=5, pc=6 after UPC.
- MOV R0,#-3 (0xD0FD), `mem_ready` tied 1 → `write`=1, `nsel`=001, `vsel`=0100 in cycle 4, back to IF1 in cycle 5.
- Fetch with `mem_ready` low 3 cycles → state held in IF1 3 extra cycles, `mem_addr` constant, `load_ir` only after ready.
- LDR (0x6041), datapath_out=0x1A → MRD at `mem_addr`=0x1A. LWB asserts `vsel`=1000, `nsel`=010, `write`=1.
- BLT imm8=0xFE at pc=10: N=1, V=0 → pc=9. N=V=0 → pc stays 11.
- HALT (0xE000), then MOV encodings on `ir` → `halted` stays 1, `mem_cmd`=00. Reset asserted mid-MWR → `mem_cmd` drops to 00 the same cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the SIMPLE multicycle controller: states, memory commands,
// opcode and select encodings, branch condition codes and the per-state control decode.
package mc_pkg;

  typedef enum logic [4:0] {
    ST_RST, ST_IF1, ST_IF2, ST_UPC, ST_WRI, ST_GETA, ST_GETB, ST_ALU, ST_ALU_SH,
    ST_WB, ST_CMPS, ST_ADDR, ST_LDA, ST_MRD, ST_LWB, ST_GETD, ST_PASS, ST_MWR,
    ST_BR, ST_HALT
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // {opcode, op} as found in ir[15:11]
  localparam logic [4:0] OP_MOV_IMM = 5'b11010;
  localparam logic [4:0] OP_MOV_SH  = 5'b11000;
  localparam logic [4:0] OP_MVN     = 5'b10111;
  localparam logic [4:0] OP_ADD     = 5'b10100;
  localparam logic [4:0] OP_CMP     = 5'b10101;
  localparam logic [4:0] OP_AND     = 5'b10110;
  localparam logic [4:0] OP_LDR     = 5'b01100;
  localparam logic [4:0] OP_STR     = 5'b10000;
  localparam logic [4:0] OP_B       = 5'b00100;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [3:0] VSEL_MDATA  = 4'b1000;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_PC     = 4'b0010;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  typedef struct packed {
    logic [1:0] mem_cmd;
    logic       load_ir;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       halted;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_IF1:    c.mem_cmd = MEM_READ;
      ST_IF2:    begin c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
      ST_WRI:    begin c.nsel = NSEL_RN; c.vsel = VSEL_SXIMM8; c.write = 1'b1; end
      ST_GETA:   begin c.nsel = NSEL_RN; c.loada = 1'b1; end
      ST_GETB:   begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
      ST_ALU:    c.loadc = 1'b1;
      ST_ALU_SH: begin c.asel = 1'b1; c.loadc = 1'b1; end
      ST_WB:     begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
      ST_CMPS:   c.loads = 1'b1;
      ST_ADDR:   begin c.bsel = 1'b1; c.loadc = 1'b1; end
      ST_MRD:    c.mem_cmd = MEM_READ;
      ST_LWB:    begin c.mem_cmd = MEM_READ; c.nsel = NSEL_RD; c.vsel = VSEL_MDATA; c.write = 1'b1; end
      ST_GETD:   begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
      ST_PASS:   begin c.asel = 1'b1; c.loadc = 1'b1; end
      ST_MWR:    c.mem_cmd = MEM_WRITE;
      ST_HALT:   c.halted = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_branch_cond.sv
// Branch condition evaluation from the datapath status flags.
module mc_branch_cond
  import mc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  output logic       taken
);

  // Reserved condition codes never branch.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = Z;
      COND_NE: taken = ~Z;
      COND_LT: taken = N ^ V;
      COND_LE: taken = (N ^ V) | Z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: fetch with ready handshake, decode, execute, write-back,
// LDR/STR data access and conditional branches. Owns the PC and data-address registers.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned RESET_PC  = 0,
  parameter bit          BRANCH_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ir,
  input  logic              N,
  input  logic              V,
  input  logic              Z,
  input  logic [ADDR_W-1:0] datapath_out,
  input  logic              mem_ready,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              load_ir,
  output logic [2:0]        nsel,
  output logic [3:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              write,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [ADDR_W-1:0] daddr_r, daddr_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s, mem_addr_r;
  ctrl_t             ctrl_r;
  logic [4:0]        op_s;
  logic [ADDR_W-1:0] imm_s;
  logic              taken_s;

  assign op_s  = ir[15:11];
  assign imm_s = ADDR_W'($signed(ir[7:0]));

  mc_branch_cond u_cond (
    .cond  (ir[10:8]),
    .N     (N),
    .V     (V),
    .Z     (Z),
    .taken (taken_s)
  );

  // Next state, PC and data address.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    daddr_nxt_s = daddr_r;
    case (state_r)
      ST_RST:  state_nxt_s = ST_IF1;
      ST_IF1:  if (mem_ready) state_nxt_s = ST_IF2; else state_nxt_s = ST_IF1;
      ST_IF2:  state_nxt_s = ST_UPC;
      ST_UPC: begin
        pc_nxt_s = pc_r + ADDR_W'(1);
        case (op_s)
          OP_MOV_IMM:                               state_nxt_s = ST_WRI;
          OP_MOV_SH, OP_MVN:                        state_nxt_s = ST_GETB;
          OP_ADD, OP_AND, OP_CMP, OP_LDR, OP_STR:   state_nxt_s = ST_GETA;
          OP_B: if (BRANCH_EN) state_nxt_s = ST_BR; else state_nxt_s = ST_HALT;
          default:                                  state_nxt_s = ST_HALT;
        endcase
      end
      ST_WRI:  state_nxt_s = ST_IF1;
      ST_GETA: if (op_s == OP_LDR || op_s == OP_STR) state_nxt_s = ST_ADDR; else state_nxt_s = ST_GETB;
      ST_GETB: begin
        case (op_s)
          OP_MOV_SH, OP_MVN: state_nxt_s = ST_ALU_SH;
          OP_CMP:            state_nxt_s = ST_CMPS;
          default:           state_nxt_s = ST_ALU;
        endcase
      end
      ST_ALU, ST_ALU_SH: state_nxt_s = ST_WB;
      ST_WB, ST_CMPS:    state_nxt_s = ST_IF1;
      ST_ADDR: state_nxt_s = ST_LDA;
      ST_LDA: begin
        daddr_nxt_s = datapath_out;
        if (op_s == OP_LDR) state_nxt_s = ST_MRD; else state_nxt_s = ST_GETD;
      end
      ST_MRD:  if (mem_ready) state_nxt_s = ST_LWB; else state_nxt_s = ST_MRD;
      ST_LWB:  state_nxt_s = ST_IF1;
      ST_GETD: state_nxt_s = ST_PASS;
      ST_PASS: state_nxt_s = ST_MWR;
      ST_MWR:  if (mem_ready) state_nxt_s = ST_IF1; else state_nxt_s = ST_MWR;
      ST_BR: begin
        if (taken_s) pc_nxt_s = pc_r + imm_s; else pc_nxt_s = pc_r;
        state_nxt_s = ST_IF1;
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_HALT;
    endcase
  end

  // Memory address presented in the state being entered.
  always_comb begin
    addr_nxt_s = '0;
    case (state_nxt_s)
      ST_IF1, ST_IF2:         addr_nxt_s = pc_nxt_s;
      ST_MRD, ST_LWB, ST_MWR: addr_nxt_s = daddr_nxt_s;
      default:                addr_nxt_s = '0;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RST;
      pc_r       <= PC_INIT;
      daddr_r    <= '0;
      mem_addr_r <= '0;
      ctrl_r     <= '0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      daddr_r    <= daddr_nxt_s;
      mem_addr_r <= addr_nxt_s;
      ctrl_r     <= ctrl_decode(state_nxt_s);
    end
  end

  assign pc       = pc_r;
  assign mem_addr = mem_addr_r;
  assign mem_cmd  = ctrl_r.mem_cmd;
  assign load_ir  = ctrl_r.load_ir;
  assign nsel     = ctrl_r.nsel;
  assign vsel     = ctrl_r.vsel;
  assign loada    = ctrl_r.loada;
  assign loadb    = ctrl_r.loadb;
  assign loadc    = ctrl_r.loadc;
  assign loads    = ctrl_r.loads;
  assign asel     = ctrl_r.asel;
  assign bsel     = ctrl_r.bsel;
  assign write    = ctrl_r.write;
  assign halted   = ctrl_r.halted;

endmodule
